// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues word reads for incoming PCs and returns
// fetched instructions, each paired with its PC, to decode in program order.
module instr_fetch_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = PTR_W + 2;

    logic [ADDR_W-1:0] r_pc   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_filled;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_fill_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_drop_cnt;
    // Allocated entries still waiting for their response.
    logic [CNT_W-1:0]  r_pend;

    logic w_credit_ok;
    logic w_req_valid;
    logic w_fire;
    logic w_rsp_drop;
    logic w_rsp_fill;
    logic w_inst_valid;
    logic w_pop;

    // Every request in flight owns either a queue slot or a drop credit.
    assign w_credit_ok  = ({1'b0, r_count} + {1'b0, r_drop_cnt}) < SUM_W'(DEPTH);
    // Gating with reset keeps the request outputs low while reset is held.
    assign w_req_valid  = pc_valid & w_credit_ok & ~flush & reset;
    assign w_fire       = w_req_valid & mem_req_ready;
    assign w_rsp_drop   = mem_rsp_valid & (r_drop_cnt != '0);
    assign w_rsp_fill   = mem_rsp_valid & (r_drop_cnt == '0);
    assign w_inst_valid = r_filled[r_rd_ptr] & (r_count != '0) & ~flush;
    assign w_pop        = w_inst_valid & inst_ready;

    assign mem_req_valid = w_req_valid;
    assign pc_ready      = w_fire;
    assign mem_req_addr  = {pc_in[ADDR_W-1:2], 2'b00};
    assign inst_valid    = w_inst_valid;
    assign inst_data     = r_data[r_rd_ptr];
    assign inst_pc       = r_pc[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_fill_ptr <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pend     <= '0;
            // Outstanding fetches become drops; a response this cycle retires one.
            r_drop_cnt <= r_drop_cnt + r_pend - CNT_W'(mem_rsp_valid);
        end else begin
            if (w_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rsp_fill) begin
                r_fill_ptr <= r_fill_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
            r_count <= r_count + CNT_W'(w_fire) - CNT_W'(w_pop);
            r_pend  <= r_pend + CNT_W'(w_fire) - CNT_W'(w_rsp_fill);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_data[i] <= '0;
            end
            r_filled <= '0;
        end else if (flush) begin
            r_filled <= '0;
        end else begin
            if (w_fire) begin
                r_pc[r_wr_ptr]     <= pc_in;
                r_filled[r_wr_ptr] <= 1'b0;
            end
            if (w_pop) begin
                r_filled[r_rd_ptr] <= 1'b0;
            end
            // Fill last: a fill never targets the entry being allocated or popped.
            if (w_rsp_fill) begin
                r_data[r_fill_ptr]   <= mem_rsp_data;
                r_filled[r_fill_ptr] <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // A response with nothing pending and nothing to drop means memory misbehaved.
    always @(posedge clk) begin
        if (reset) begin
            assert (!(mem_rsp_valid && r_drop_cnt == '0 && r_pend == '0));
        end
    end
`endif

endmodule
